// File: rtl/keypad_pkg.sv
// Shared constants, FSM encoding and key-map helpers for the keypad entry controller.
package keypad_pkg;

    localparam int unsigned ROW_W  = 2;
    localparam int unsigned COL_W  = 2;
    localparam int unsigned CODE_W = 4;

    localparam logic [CODE_W-1:0] KEY_C = 4'd10;
    localparam logic [CODE_W-1:0] KEY_M = 4'd11;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2
    } kp_state_e;

    // Keypad layout 1 2 3 / 4 5 6 / 7 8 9 / C 0 M.
    function automatic logic [CODE_W-1:0] key_code_of(input logic [ROW_W-1:0] row,
                                                      input logic [COL_W-1:0] col);
        logic [CODE_W-1:0] code;
        if (row == 2'd3) begin
            case (col)
                2'd0:    code = KEY_C;
                2'd1:    code = 4'd0;
                default: code = KEY_M;
            endcase
        end else begin
            code = 4'(row) * 4'd3 + 4'(col) + 4'd1;
        end
        return code;
    endfunction

    // Overlay region index, row-major over the 4x3 grid.
    function automatic logic [3:0] hl_index_of(input logic [ROW_W-1:0] row,
                                               input logic [COL_W-1:0] col);
        return 4'(row) * 4'd3 + 4'(col);
    endfunction

    function automatic logic is_digit(input logic [CODE_W-1:0] code);
        return (code <= 4'd9);
    endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Scan-tick prescaler: one-cycle strobe every CLK_DIV pclk cycles.
module keypad_tick_gen #(
    parameter int unsigned CLK_DIV = 50000
) (
    input  logic pclk,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Free-running divider; strobe registered on wrap.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == CNT_MAX) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + CNT_W'(1);
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/keypad_entry_ctrl.sv
// 4x3 keypad scanner, debouncer and BCD entry accumulator.
// Optional build macro: KEYPAD_REPEAT_EN enables auto-repeat of held digit keys.
module keypad_entry_ctrl
    import keypad_pkg::*;
#(
    parameter int unsigned CLK_DIV     = 50000,
    parameter int unsigned DEB_TICKS   = 10,
    parameter int unsigned DIGITS      = 3,
    parameter int unsigned REPEAT_DLY  = 500,
    parameter int unsigned REPEAT_RATE = 100
) (
    input  logic                  pclk,
    input  logic                  rst_n,
    output logic [3:0]            row_o,
    input  logic [2:0]            col_i,
    output logic                  key_valid,
    output logic [3:0]            key_code,
    output logic                  hl_en,
    output logic [3:0]            hl_idx,
    output logic [4*DIGITS-1:0]   entry_bcd,
    output logic [3:0]            entry_len,
    output logic                  value_commit,
    output logic [4*DIGITS-1:0]   value_out
);

    localparam int unsigned ENT_W = 4 * DIGITS;
    localparam int unsigned DEB_W = $clog2(DEB_TICKS + 1);
    localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_TICKS);
    localparam logic [3:0]       LEN_MAX = 4'(DIGITS);

    // Reject parameter sets the datapath cannot represent.
    if (CLK_DIV < 2 || DEB_TICKS == 0 || DIGITS == 0 || DIGITS > 15 ||
        REPEAT_DLY == 0 || REPEAT_RATE == 0) begin : g_param_err
        $error("keypad_entry_ctrl: invalid parameter set");
    end

    logic            tick;
    logic [2:0]      col_meta;
    logic [2:0]      col_sync;
    kp_state_e       state, state_nxt;
    logic [1:0]      row_ptr, row_ptr_nxt;
    logic [1:0]      cap_col, cap_col_nxt;
    logic [DEB_W-1:0] deb_cnt, deb_cnt_nxt;
    logic            any_low_c;
    logic [1:0]      first_low_c;
    logic            cap_low_c;
    logic [DEB_W-1:0] deb_inc_c;
    logic            deb_done_c;
    logic            accept_c;
    logic            release_c;
    logic            repeat_c;

    keypad_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .pclk  (pclk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // Two-flop synchronizer; columns idle high through the pull-ups.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            col_meta <= 3'b111;
            col_sync <= 3'b111;
        end else begin
            col_meta <= col_i;
            col_sync <= col_meta;
        end
    end

    // Column decode: lowest low column wins, plus the captured column's level.
    always_comb begin
        any_low_c   = (col_sync != 3'b111);
        first_low_c = 2'd2;
        if (!col_sync[0])      first_low_c = 2'd0;
        else if (!col_sync[1]) first_low_c = 2'd1;
        cap_low_c   = !col_sync[cap_col];
        deb_inc_c   = deb_cnt + DEB_W'(1);
        deb_done_c  = (deb_inc_c == DEB_MAX);
    end

    // FSM state register.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) state <= ST_SCAN;
        else        state <= state_nxt;
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_SCAN: begin
                if (tick && any_low_c)
                    state_nxt = (DEB_TICKS == 1) ? ST_PRESSED : ST_DEBOUNCE;
            end
            ST_DEBOUNCE: begin
                if (tick) begin
                    if (!cap_low_c)      state_nxt = ST_SCAN;
                    else if (deb_done_c) state_nxt = ST_PRESSED;
                end
            end
            ST_PRESSED: begin
                if (tick && !cap_low_c && deb_done_c) state_nxt = ST_SCAN;
            end
            default: state_nxt = ST_SCAN;
        endcase
    end

    // FSM outputs: row/column/counter updates and press/release strobes.
    always_comb begin
        row_ptr_nxt = row_ptr;
        cap_col_nxt = cap_col;
        deb_cnt_nxt = deb_cnt;
        accept_c    = 1'b0;
        release_c   = 1'b0;
        unique case (state)
            ST_SCAN: begin
                if (tick) begin
                    if (any_low_c) begin
                        cap_col_nxt = first_low_c;
                        if (DEB_TICKS == 1) begin
                            accept_c    = 1'b1;
                            deb_cnt_nxt = '0;
                        end else begin
                            deb_cnt_nxt = DEB_W'(1);
                        end
                    end else begin
                        row_ptr_nxt = row_ptr + 2'd1;
                    end
                end
            end
            ST_DEBOUNCE: begin
                if (tick) begin
                    if (!cap_low_c) begin
                        deb_cnt_nxt = '0;
                    end else if (deb_done_c) begin
                        accept_c    = 1'b1;
                        deb_cnt_nxt = '0;
                    end else begin
                        deb_cnt_nxt = deb_inc_c;
                    end
                end
            end
            ST_PRESSED: begin
                if (tick) begin
                    if (cap_low_c) begin
                        deb_cnt_nxt = '0;
                    end else if (deb_done_c) begin
                        release_c   = 1'b1;
                        deb_cnt_nxt = '0;
                        row_ptr_nxt = row_ptr + 2'd1;
                    end else begin
                        deb_cnt_nxt = deb_inc_c;
                    end
                end
            end
            default: begin
                deb_cnt_nxt = '0;
            end
        endcase
    end

    // Scan datapath registers and row drive.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            row_ptr <= '0;
            cap_col <= '0;
            deb_cnt <= '0;
            row_o   <= 4'b1111;
        end else begin
            row_ptr <= row_ptr_nxt;
            cap_col <= cap_col_nxt;
            deb_cnt <= deb_cnt_nxt;
            row_o   <= ~(4'b0001 << row_ptr_nxt);
        end
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0] rpt_cnt, rpt_cnt_nxt;
    logic [RPT_W-1:0] rpt_lim_c;
    logic             rpt_armed, rpt_armed_nxt;

    // Held-digit repeat: first interval REPEAT_DLY, then REPEAT_RATE.
    always_comb begin
        rpt_cnt_nxt   = rpt_cnt;
        rpt_armed_nxt = rpt_armed;
        repeat_c      = 1'b0;
        rpt_lim_c     = rpt_armed ? RPT_W'(REPEAT_RATE) : RPT_W'(REPEAT_DLY);
        if (accept_c) begin
            rpt_cnt_nxt   = '0;
            rpt_armed_nxt = 1'b0;
        end else if (state == ST_PRESSED && tick && cap_low_c && is_digit(key_code)) begin
            if (rpt_cnt + RPT_W'(1) == rpt_lim_c) begin
                repeat_c      = 1'b1;
                rpt_cnt_nxt   = '0;
                rpt_armed_nxt = 1'b1;
            end else begin
                rpt_cnt_nxt = rpt_cnt + RPT_W'(1);
            end
        end
    end

    // Repeat counter registers.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt   <= '0;
            rpt_armed <= 1'b0;
        end else begin
            rpt_cnt   <= rpt_cnt_nxt;
            rpt_armed <= rpt_armed_nxt;
        end
    end
`else
    assign repeat_c = 1'b0;
`endif

    // Key event and overlay highlight registers.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            key_valid <= 1'b0;
            key_code  <= '0;
            hl_en     <= 1'b0;
            hl_idx    <= '0;
        end else begin
            key_valid <= accept_c | repeat_c;
            if (accept_c) begin
                key_code <= key_code_of(row_ptr, cap_col_nxt);
                hl_idx   <= hl_index_of(row_ptr, cap_col_nxt);
                hl_en    <= 1'b1;
            end else if (release_c) begin
                hl_en    <= 1'b0;
            end
        end
    end

    // BCD entry accumulation and commit, one cycle after each key event.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            entry_bcd    <= '0;
            entry_len    <= '0;
            value_commit <= 1'b0;
            value_out    <= '0;
        end else begin
            value_commit <= 1'b0;
            if (key_valid) begin
                if (key_code == KEY_C) begin
                    entry_bcd <= '0;
                    entry_len <= '0;
                end else if (key_code == KEY_M) begin
                    if (entry_len != 4'd0) begin
                        value_out    <= entry_bcd;
                        value_commit <= 1'b1;
                        entry_bcd    <= '0;
                        entry_len    <= '0;
                    end
                end else if (entry_len < LEN_MAX) begin
                    entry_bcd <= (entry_bcd << 4) | ENT_W'(key_code);
                    entry_len <= entry_len + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Self-checking bench for keypad_entry_ctrl: directed scenarios plus random key sequences
// checked against a keypad-level reference model. Honors KEYPAD_REPEAT_EN.
module tb_keypad_entry_ctrl;

    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned DEB     = 3;
    localparam int unsigned DIGITS  = 3;
    localparam int unsigned RDLY    = 6;
    localparam int unsigned RRATE   = 2;
`ifdef KEYPAD_REPEAT_EN
    localparam bit REPEAT_ON = 1'b1;
`else
    localparam bit REPEAT_ON = 1'b0;
`endif

    logic        pclk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  row_o;
    logic [2:0]  col_i;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        hl_en;
    logic [3:0]  hl_idx;
    logic [11:0] entry_bcd;
    logic [3:0]  entry_len;
    logic        value_commit;
    logic [11:0] value_out;

    keypad_entry_ctrl #(
        .CLK_DIV(CLK_DIV), .DEB_TICKS(DEB), .DIGITS(DIGITS),
        .REPEAT_DLY(RDLY), .REPEAT_RATE(RRATE)
    ) dut (
        .pclk(pclk), .rst_n(rst_n), .row_o(row_o), .col_i(col_i),
        .key_valid(key_valid), .key_code(key_code), .hl_en(hl_en), .hl_idx(hl_idx),
        .entry_bcd(entry_bcd), .entry_len(entry_len),
        .value_commit(value_commit), .value_out(value_out)
    );

    always #5 pclk = ~pclk;

    // Physical keypad: the pressed key shorts its column to its row while that row is low.
    logic       key_down = 1'b0;
    logic [1:0] key_row  = 2'd0;
    logic [1:0] key_col  = 2'd0;
    always_comb begin
        col_i = 3'b111;
        if (key_down && row_o[key_row] == 1'b0) col_i[key_col] = 1'b0;
    end

    // Event monitor: counts pulses and stamps key events with the cycle number.
    int cyc = 0;
    int kv_cnt = 0;
    int cm_cnt = 0;
    int kv_times[$];
    always @(posedge pclk) begin
        cyc <= cyc + 1;
        if (key_valid) begin
            kv_cnt <= kv_cnt + 1;
            kv_times.push_back(cyc);
        end
        if (value_commit) cm_cnt <= cm_cnt + 1;
    end

    // Reference model: key labels in row-major order and the entry/commit state.
    int code_map[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0, 11};
    int m_ent = 0;
    int m_len = 0;
    int m_val = 0;
    int m_commits = 0;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_key(input int code);
        if (code <= 9) begin
            if (m_len < DIGITS) begin
                m_ent = m_ent * 16 + code;
                m_len = m_len + 1;
            end
        end else if (code == 10) begin
            m_ent = 0;
            m_len = 0;
        end else if (m_len > 0) begin
            m_val = m_ent;
            m_commits = m_commits + 1;
            m_ent = 0;
            m_len = 0;
        end
    endfunction

    // Repeats expected for h low-sampled ticks after the accepting tick.
    function automatic int n_repeats(input int code, input int h);
        if (!REPEAT_ON || code > 9 || h < RDLY) return 0;
        return 1 + (h - RDLY) / RRATE;
    endfunction

    task automatic check_entry(input string tag);
        check({tag, "_entry_bcd"}, 32'(entry_bcd), m_ent);
        check({tag, "_entry_len"}, 32'(entry_len), m_len);
        check({tag, "_value_out"}, 32'(value_out), m_val);
        check({tag, "_commits"},   cm_cnt, m_commits);
    endtask

    // Press (r,c), optionally with a short bounce first; hold h ticks after acceptance.
    task automatic press(input int r, input int c, input int h, input bit bounce);
        int base, tbase, code, nrep;
        bit seen;
        code = code_map[r*3+c];
        key_row = 2'(r);
        key_col = 2'(c);
        base = kv_cnt;
        if (bounce) begin
            key_down = 1'b1;
            repeat (2*CLK_DIV) @(negedge pclk);
            key_down = 1'b0;
            repeat (CLK_DIV) @(negedge pclk);
            check("bounce_quiet", kv_cnt - base, 0);
        end
        tbase = kv_times.size();
        key_down = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge pclk);
            if (key_valid) seen = 1'b1;
        end
        check("press_seen", 32'(seen), 1);
        check("key_code", 32'(key_code), code);
        check("hl_en_on", 32'(hl_en), 1);
        check("hl_idx", 32'(hl_idx), r*3+c);
        repeat (h*CLK_DIV) @(negedge pclk);
        key_down = 1'b0;
        repeat (8) @(negedge pclk);
        check("hl_en_hold", 32'(hl_en), 1);
        for (int i = 0; i < 60 && hl_en; i++) @(negedge pclk);
        check("hl_en_off", 32'(hl_en), 0);
        repeat (3) @(negedge pclk);
        nrep = n_repeats(code, h);
        check("events_per_press", kv_cnt - base, 1 + nrep);
        if (nrep > 0 && kv_times.size() == tbase + 1 + nrep) begin
            for (int j = 1; j <= nrep; j++)
                check("repeat_gap", kv_times[tbase+j] - kv_times[tbase+j-1],
                      ((j == 1) ? RDLY : RRATE) * CLK_DIV);
        end
        for (int j = 0; j <= nrep; j++) model_key(code);
        check_entry("after_key");
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_row;
        bit seen;
        int r, c;

        // Reset values
        repeat (3) @(negedge pclk);
        check("rst_row_o", 32'(row_o), 32'hF);
        check("rst_key_valid", 32'(key_valid), 0);
        check("rst_hl_en", 32'(hl_en), 0);
        check("rst_key_code", 32'(key_code), 0);
        check_entry("rst");

        // Idle scanning: one row per tick, no events
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge pclk);
            exp_row = 4'b1111 ^ (4'b0001 << ((k - 1) / 4));
            check("idle_row_o", 32'(row_o), 32'(exp_row));
        end
        repeat (20) @(negedge pclk);
        check("idle_no_events", kv_cnt, 0);

        // "6" held 10 ticks in total
        press(1, 2, 7, 1'b0);
        // "5" with bounce ahead of the real press
        press(1, 1, 1, 1'b1);
        // Clear, then 1 2 3 4 (4 dropped), then commit
        press(3, 0, 0, 1'b0);
        press(0, 0, 0, 1'b0);
        press(0, 1, 1, 1'b0);
        press(0, 2, 0, 1'b0);
        press(1, 0, 2, 1'b0);
        check("full_entry", 32'(entry_bcd), 32'h123);
        press(3, 2, 0, 1'b0);
        check("commit_value", 32'(value_out), 32'h123);
        // 7, C, M: nothing committed
        press(2, 0, 0, 1'b0);
        press(3, 0, 1, 1'b0);
        press(3, 2, 0, 1'b0);
        check("no_commit_value", 32'(value_out), 32'h123);

        // Long holds: digit repeats only in the repeat build, M never repeats
        press(3, 0, 0, 1'b0);
        press(2, 1, 11, 1'b0);
        press(3, 2, 11, 1'b0);

        // Random key sequences
        for (int n = 0; n < 30; n++) begin
            r = $urandom_range(0, 3);
            c = $urandom_range(0, 2);
            press(r, c, $urandom_range(0, 3), 1'b0);
            repeat ($urandom_range(0, 4) * CLK_DIV) @(negedge pclk);
        end

        // Reset during a held press, then re-debounce of the still-held key
        key_row = 2'd2;
        key_col = 2'd2;
        key_down = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge pclk);
            if (key_valid) seen = 1'b1;
        end
        check("mid_press_seen", 32'(seen), 1);
        repeat (2) @(negedge pclk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_row_o", 32'(row_o), 32'hF);
        check("mid_rst_hl_en", 32'(hl_en), 0);
        check("mid_rst_key_code", 32'(key_code), 0);
        check("mid_rst_hl_idx", 32'(hl_idx), 0);
        check("mid_rst_entry", 32'(entry_bcd), 0);
        check("mid_rst_len", 32'(entry_len), 0);
        check("mid_rst_value", 32'(value_out), 0);
        m_ent = 0;
        m_len = 0;
        m_val = 0;
        @(negedge pclk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge pclk);
            if (key_valid) seen = 1'b1;
        end
        check("rearm_seen", 32'(seen), 1);
        check("rearm_code", 32'(key_code), 9);
        key_down = 1'b0;
        for (int i = 0; i < 60 && hl_en; i++) @(negedge pclk);
        check("rearm_hl_off", 32'(hl_en), 0);
        model_key(9);
        check("rearm_entry", 32'(entry_bcd), m_ent);
        check("rearm_len", 32'(entry_len), m_len);
        check("rearm_value", 32'(value_out), m_val);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
